pll_lock_reset: RTL



---
 rtl/pll_lock_reset_pkg.sv | 20 ++
 rtl/pll_lock_reset_sync_chain.sv | 26 ++
 rtl/pll_lock_reset.sv | 103 ++++++++++
 3 files changed

// File: rtl/pll_lock_reset_pkg.sv
// Shared definitions for the PLL lock reset sequencer.
// State encoding is fixed at 2 bits: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
// cnt_width() sizes the shared window counter so it can hold max(stable, hold) - 1.
package pll_lock_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Bits needed to count from 0 up to max(stable_cycles, hold_cycles) - 1.
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int max_val;
    max_val = ((stable_cycles > hold_cycles) ? stable_cycles : hold_cycles) - 1;
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_reset_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input.
// Latency: STAGES clock edges from d to q.
// Backpressure: none; samples every cycle.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the flop chain; bit 0 is the metastable stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_reset.sv
// Reset sequencer: holds sys_reset until synchronised lock is stable for STABLE_CYCLES then HOLD_CYCLES.
// Latency: sys_reset falls SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges after lock is first sampled.
// Backpressure: none; loss of lock in RUN re-asserts reset, pulses lock_lost and bumps a saturating counter.
module pll_lock_reset
  import pll_lock_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_W        = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lock,
  output logic              sys_reset,
  output logic              sys_ready,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = {LOSS_W{1'b1}};

  logic          lock_s;
  state_t        state;
  logic [CW-1:0] cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (lock),
    .q       (lock_s)
  );

  // Sequencer FSM; outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      sys_reset  <= 1'b1;
      sys_ready  <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      // Default: remain in reset, no loss pulse. Only entering/staying in RUN releases reset.
      sys_reset <= 1'b1;
      sys_ready <= 1'b0;
      lock_lost <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          // Any low sample restarts the whole window; no partial credit.
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (cnt == HOLD_LAST) begin
            state     <= RUN;
            sys_reset <= 1'b0;
            sys_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // Only a drop from RUN is a real loss of lock; it is reported and counted.
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            lock_lost <= 1'b1;
            if (loss_count != LOSS_MAX) begin
              loss_count <= loss_count + 1'b1;
            end
          end else begin
            sys_reset <= 1'b0;
            sys_ready <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
